// File: rtl/game_state_ctrl_pkg.sv
// Shared types for the game sequencer: FSM state encoding and tick-period width.
package game_state_ctrl_pkg;

    typedef enum logic [2:0] {
        GS_IDLE  = 3'd0,
        GS_CLEAR = 3'd1,
        GS_PLAY  = 3'd2,
        GS_PAUSE = 3'd3,
        GS_OVER  = 3'd4,
        GS_WON   = 3'd5
    } gs_state_t;

    // frames_per_tick is a 4-bit quantity (BASE_FRAMES must fit in it)
    localparam int FPT_W = 4;

    // States in which game_logic is held in reset
    function automatic logic holds_game_reset(gs_state_t s);
        return (s == GS_IDLE) || (s == GS_CLEAR);
    endfunction

    // Terminal states that wait for a restart
    function automatic logic is_end_state(gs_state_t s);
        return (s == GS_OVER) || (s == GS_WON);
    endfunction

endpackage

// File: rtl/game_state_ctrl_btn_edge_sync.sv
// Button synchroniser: two flops into clk, then a one-cycle rising-edge pulse.
// All flops reset to 1 so a button held through reset does not look like a press.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Metastability chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: runs the idle/clear/play/pause/over/won FSM, drives
// game_logic's reset, and issues the frame-aligned update tick whose period
// shrinks as the score (tail_count) grows.
// Optional feature: GAME_CTRL_AUTORESTART_EN -- OVER/WON fall back to CLEAR
// after 180 frame_start pulses.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | power-up; game_logic held in reset, waiting for start
//  CLEAR | game_logic held in reset for RST_CYCLES clk, counters reloaded
//  PLAY  | game running; ticks issued, joystick accepted
//  PAUSE | frozen; pause resumes, start restarts
//  OVER  | snake died; waits for start
//  WON   | board filled; waits for start
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int TAIL_W       = 8,
    parameter int BASE_FRAMES  = 12,
    parameter int MIN_FRAMES   = 3,
    parameter int SPEEDUP_STEP = 4,
    parameter int RST_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              start_btn,
    input  logic              pause_btn,
    input  logic              game_over,
    input  logic              game_won,
    input  logic [TAIL_W-1:0] tail_count,
    output logic              upd_tick,
    output logic              game_rst_n,
    output logic              dir_en,
    output logic [2:0]        state,
    output logic [FPT_W-1:0]  frames_per_tick
);

    localparam int SPEED_SHIFT = $clog2(SPEEDUP_STEP);
    localparam int RST_W       = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

    gs_state_t         state_q;
    gs_state_t         state_d;
    logic              start_rise;
    logic              pause_rise;
    logic [RST_W-1:0]  rst_cnt;
    logic [FPT_W-1:0]  frame_cnt;
    logic [FPT_W-1:0]  fpt_next;
    logic [TAIL_W:0]   speed_sub;
    logic              frame_hit;
    logic              timeout_hit;

    btn_edge_sync u_start_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (start_btn),
        .rise  (start_rise)
    );

    btn_edge_sync u_pause_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (pause_btn),
        .rise  (pause_rise)
    );

    // One extra bit on the subtraction so a large score shows up as a borrow
    assign speed_sub = (TAIL_W+1)'(BASE_FRAMES) - {1'b0, (tail_count >> SPEED_SHIFT)};

    // Next tick period, floored at MIN_FRAMES
    always_comb begin
        fpt_next = speed_sub[FPT_W-1:0];
        if (speed_sub[TAIL_W] || (speed_sub < (TAIL_W+1)'(MIN_FRAMES))) begin
            fpt_next = FPT_W'(MIN_FRAMES);
        end
    end

    assign frame_hit = (state_q == GS_PLAY) && frame_start &&
                       (frame_cnt == (frames_per_tick - FPT_W'(1)));

`ifdef GAME_CTRL_AUTORESTART_EN
    localparam int AUTORESTART_FRAMES = 180;

    logic [7:0] timeout_cnt;

    // Reload outside OVER/WON; count frame_start pulses down while waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_cnt <= 8'(AUTORESTART_FRAMES - 1);
        end else if (!is_end_state(state_q)) begin
            timeout_cnt <= 8'(AUTORESTART_FRAMES - 1);
        end else if (frame_start && (timeout_cnt != '0)) begin
            timeout_cnt <= timeout_cnt - 8'd1;
        end
    end

    assign timeout_hit = is_end_state(state_q) && frame_start && (timeout_cnt == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; won outranks over, over outranks pause, start outranks pause
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GS_IDLE: begin
                if (start_rise) state_d = GS_CLEAR;
            end
            GS_CLEAR: begin
                if (rst_cnt == '0) state_d = GS_PLAY;
            end
            GS_PLAY: begin
                if (game_won)        state_d = GS_WON;
                else if (game_over)  state_d = GS_OVER;
                else if (pause_rise) state_d = GS_PAUSE;
            end
            GS_PAUSE: begin
                if (start_rise)      state_d = GS_CLEAR;
                else if (pause_rise) state_d = GS_PLAY;
            end
            GS_OVER, GS_WON: begin
                if (start_rise || timeout_hit) state_d = GS_CLEAR;
            end
            default: state_d = GS_IDLE;
        endcase
    end

    // CLEAR dwell timer: preloaded outside CLEAR, counts down to terminal zero inside
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt <= RST_LOAD;
        end else if (state_q != GS_CLEAR) begin
            rst_cnt <= RST_LOAD;
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - RST_W'(1);
        end
    end

    // Frame counter and tick period; period only changes at a tick boundary or in CLEAR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt       <= '0;
            frames_per_tick <= FPT_W'(BASE_FRAMES);
        end else if (state_q == GS_CLEAR) begin
            frame_cnt       <= '0;
            frames_per_tick <= fpt_next;
        end else if (frame_hit) begin
            frame_cnt       <= '0;
            frames_per_tick <= fpt_next;
        end else if ((state_q == GS_PLAY) && frame_start) begin
            frame_cnt       <= frame_cnt + FPT_W'(1);
        end
    end

    // Registered outputs, decoded from the next state so they align with state_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_tick   <= 1'b0;
            game_rst_n <= 1'b0;
            dir_en     <= 1'b0;
        end else begin
            upd_tick   <= frame_hit;
            game_rst_n <= !holds_game_reset(state_d);
            dir_en     <= (state_d == GS_PLAY);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl. Expected tick timing and tick
// periods come from a frame-level model (frames since last tick, period from
// the score formula). Honours GAME_CTRL_AUTORESTART_EN when defined.
module tb_game_state_ctrl;

    localparam int BASE = 12;
    localparam int MINF = 3;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [2:0] S_WON   = 3'd5;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       start_btn;
    logic       pause_btn;
    logic       game_over;
    logic       game_won;
    logic [7:0] tail_count;
    logic       upd_tick;
    logic       game_rst_n;
    logic       dir_en;
    logic [2:0] state;
    logic [3:0] frames_per_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int dbl_cnt  = 0;
    logic prev_tick = 1'b0;
    int m_frame = 0;
    int m_fpt   = BASE;

    game_state_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .start_btn       (start_btn),
        .pause_btn       (pause_btn),
        .game_over       (game_over),
        .game_won        (game_won),
        .tail_count      (tail_count),
        .upd_tick        (upd_tick),
        .game_rst_n      (game_rst_n),
        .dir_en          (dir_en),
        .state           (state),
        .frames_per_tick (frames_per_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd_tick === 1'b1) tick_cnt++;
        if (upd_tick === 1'b1 && prev_tick === 1'b1) dbl_cnt++;
        prev_tick = upd_tick;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
        $fatal(1, "watchdog");
    end

    function automatic int fpt_of(int t);
        int v;
        v = BASE - t / 4;
        return (v < MINF) ? MINF : v;
    endfunction

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_frame();
            gap();
        end
    endtask

    task automatic press(input logic s, input logic p);
        start_btn = s;
        pause_btn = p;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        pause_btn = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    // One frame in PLAY, checked against the frame model
    task automatic play_frame();
        int t0;
        bit exp_tick;
        t0 = tick_cnt;
        pulse_frame();
        m_frame++;
        exp_tick = (m_frame == m_fpt);
        if (exp_tick) begin
            m_frame = 0;
            m_fpt   = fpt_of(int'(tail_count));
        end
        n_checks++;
        if (upd_tick !== exp_tick) begin
            n_fail++;
            $display("FAIL frame_tick: upd_tick=%b expected %b (frame %0d of %0d)", upd_tick, exp_tick, m_frame, m_fpt);
        end
        gap();
        n_checks++;
        if ((tick_cnt - t0) !== int'(exp_tick)) begin
            n_fail++;
            $display("FAIL tick_count: got %0d ticks expected %0d", tick_cnt - t0, int'(exp_tick));
        end
        n_checks++;
        if (frames_per_tick !== 4'(m_fpt)) begin
            n_fail++;
            $display("FAIL frames_per_tick: got %0d expected %0d", frames_per_tick, m_fpt);
        end
    endtask

    task automatic play_until_tick();
        int guard;
        guard = 0;
        do begin
            play_frame();
            guard++;
        end while (m_frame != 0 && guard < 20);
    endtask

    task automatic wait_play();
        int k;
        k = 0;
        while (state !== S_PLAY && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (state !== S_PLAY) begin
            n_fail++;
            $display("FAIL wait_play: state=%0d expected %0d", state, S_PLAY);
        end
        m_frame = 0;
        m_fpt   = fpt_of(int'(tail_count));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        frame_start = 1'b0;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        game_over = 1'b0;
        game_won = 1'b0;
        tail_count = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        n_checks++;
        if (upd_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", upd_tick); end
        n_checks++;
        if (game_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_game_rst_n: got %b expected 0", game_rst_n); end
        n_checks++;
        if (dir_en !== 1'b0) begin n_fail++; $display("FAIL reset_dir_en: got %b expected 0", dir_en); end
        n_checks++;
        if (frames_per_tick !== 4'(BASE)) begin n_fail++; $display("FAIL reset_fpt: got %0d expected %0d", frames_per_tick, BASE); end
        reset = 1'b1;
        settle();
    endtask

    task automatic test_start_play();
        int cnt;
        int k;
        tail_count = 8'd0;
        press(1'b1, 1'b0);
        n_checks++;
        if (state !== S_CLEAR) begin n_fail++; $display("FAIL start_to_clear: state=%0d expected %0d", state, S_CLEAR); end
        cnt = 0;
        k = 0;
        while (state === S_CLEAR && k < 20) begin
            if (game_rst_n === 1'b0) cnt++;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (cnt !== 4) begin n_fail++; $display("FAIL clear_length: game_rst_n low %0d clk in CLEAR expected 4", cnt); end
        n_checks++;
        if (state !== S_PLAY || game_rst_n !== 1'b1 || dir_en !== 1'b1) begin
            n_fail++;
            $display("FAIL enter_play: state=%0d rst_n=%b dir_en=%b expected 2/1/1", state, game_rst_n, dir_en);
        end
        m_frame = 0;
        m_fpt = fpt_of(0);
        repeat (12) play_frame();
    endtask

    task automatic test_speed();
        tail_count = 8'd20;
        play_until_tick();
        n_checks++;
        if (frames_per_tick !== 4'd7) begin n_fail++; $display("FAIL speed_20: got %0d expected 7", frames_per_tick); end
        tail_count = 8'd255;
        play_until_tick();
        n_checks++;
        if (frames_per_tick !== 4'd3) begin n_fail++; $display("FAIL speed_255: got %0d expected 3", frames_per_tick); end
        for (int i = 0; i < 6; i++) begin
            tail_count = 8'($urandom_range(0, 255));
            play_until_tick();
        end
    endtask

    task automatic test_pause();
        int t0;
        tail_count = 8'd0;
        play_until_tick();
        repeat (5) play_frame();
        press(1'b1, 1'b0);
        n_checks++;
        if (state !== S_PLAY) begin n_fail++; $display("FAIL start_in_play: state=%0d expected %0d", state, S_PLAY); end
        settle();
        press(1'b0, 1'b1);
        n_checks++;
        if (state !== S_PAUSE || dir_en !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_pause: state=%0d dir_en=%b expected 3/0", state, dir_en);
        end
        settle();
        t0 = tick_cnt;
        idle_frames(10 + $urandom_range(0, 8));
        n_checks++;
        if (tick_cnt !== t0) begin n_fail++; $display("FAIL pause_ticks: got %0d ticks expected 0", tick_cnt - t0); end
        press(1'b0, 1'b1);
        n_checks++;
        if (state !== S_PLAY || dir_en !== 1'b1) begin
            n_fail++;
            $display("FAIL resume: state=%0d dir_en=%b expected 2/1", state, dir_en);
        end
        settle();
        t0 = tick_cnt;
        repeat (6) play_frame();
        n_checks++;
        if (tick_cnt !== t0) begin n_fail++; $display("FAIL resume_early: got %0d ticks expected 0", tick_cnt - t0); end
        play_frame();
        n_checks++;
        if (tick_cnt - t0 !== 1) begin n_fail++; $display("FAIL resume_tick: got %0d ticks expected 1", tick_cnt - t0); end
        press(1'b0, 1'b1);
        settle();
        tail_count = 8'($urandom_range(0, 255));
        press(1'b1, 1'b1);
        n_checks++;
        if (state !== S_CLEAR) begin n_fail++; $display("FAIL start_wins: state=%0d expected %0d", state, S_CLEAR); end
        wait_play();
        n_checks++;
        if (frames_per_tick !== 4'(m_fpt)) begin n_fail++; $display("FAIL clear_fpt: got %0d expected %0d", frames_per_tick, m_fpt); end
        play_until_tick();
    endtask

    task automatic test_won_over();
        int t0;
        repeat (3) play_frame();
        game_over = 1'b1;
        game_won = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state !== S_WON || dir_en !== 1'b0 || game_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL won_over: state=%0d dir_en=%b rst_n=%b expected 5/0/1", state, dir_en, game_rst_n);
        end
        t0 = tick_cnt;
        idle_frames(15);
        n_checks++;
        if (tick_cnt !== t0 || state !== S_WON) begin
            n_fail++;
            $display("FAIL won_frozen: ticks=%0d state=%0d expected 0/5", tick_cnt - t0, state);
        end
        game_over = 1'b0;
        game_won = 1'b0;
        settle();
        press(1'b1, 1'b0);
        n_checks++;
        if (state !== S_CLEAR) begin n_fail++; $display("FAIL won_restart: state=%0d expected %0d", state, S_CLEAR); end
        wait_play();
        repeat (2) play_frame();
        pause_btn = 1'b1;
        repeat (2) @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        pause_btn = 1'b0;
        n_checks++;
        if (state !== S_OVER) begin n_fail++; $display("FAIL over_vs_pause: state=%0d expected %0d", state, S_OVER); end
        @(negedge clk);
        game_over = 1'b0;
        settle();
        n_checks++;
        if (state !== S_OVER || dir_en !== 1'b0) begin
            n_fail++;
            $display("FAIL over_hold: state=%0d dir_en=%b expected 4/0", state, dir_en);
        end
    endtask

    task automatic test_timeout();
        int t0;
        t0 = tick_cnt;
        idle_frames(179);
        n_checks++;
        if (state !== S_OVER || tick_cnt !== t0) begin
            n_fail++;
            $display("FAIL over_179: state=%0d ticks=%0d expected 4/0", state, tick_cnt - t0);
        end
        pulse_frame();
`ifdef GAME_CTRL_AUTORESTART_EN
        n_checks++;
        if (state !== S_CLEAR) begin n_fail++; $display("FAIL autorestart: state=%0d expected %0d", state, S_CLEAR); end
`else
        n_checks++;
        if (state !== S_OVER) begin n_fail++; $display("FAIL no_autorestart: state=%0d expected %0d", state, S_OVER); end
        settle();
        press(1'b1, 1'b0);
`endif
        wait_play();
        play_until_tick();
    endtask

    task automatic test_btn_held_reset();
        repeat (2) play_frame();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (state !== S_IDLE || game_rst_n !== 1'b0 || dir_en !== 1'b0 || upd_tick !== 1'b0 || frames_per_tick !== 4'(BASE)) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d rst_n=%b dir_en=%b tick=%b fpt=%0d expected 0/0/0/0/%0d",
                     state, game_rst_n, dir_en, upd_tick, frames_per_tick, BASE);
        end
        start_btn = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (state !== S_IDLE) begin n_fail++; $display("FAIL held_start: state=%0d expected %0d", state, S_IDLE); end
        start_btn = 1'b0;
        settle();
        press(1'b1, 1'b0);
        n_checks++;
        if (state !== S_CLEAR) begin n_fail++; $display("FAIL press_after_hold: state=%0d expected %0d", state, S_CLEAR); end
        wait_play();
        n_checks++;
        if (dbl_cnt !== 0) begin n_fail++; $display("FAIL tick_width: %0d multi-cycle ticks expected 0", dbl_cnt); end
    endtask

    initial begin
        test_reset();
        test_start_play();
        test_speed();
        test_pause();
        test_won_over();
        test_timeout();
        test_btn_held_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
